// File: rtl/imem_loader_if.sv
// Boot byte stream (valid/ready) plus the instruction-memory write port.
// master = boot link / memory side, slave = loader side.
interface imem_loader_if #(
    parameter int N = 32
) ();
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         wr_en;
    logic [N-1:0] wr_addr;
    logic [31:0]  wr_data;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: LE word count, then LE 32-bit words, written to instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int N = 32,
    parameter int H = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_start,
    imem_loader_if.slave   bus,
    output logic           cpu_hold,
    output logic           load_done,
    output logic           load_error
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK  = 3'd6
`endif
    } state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_AFTER_DATA = S_CHK;
`else
    localparam state_e S_AFTER_DATA = S_DONE;
`endif

    localparam logic [15:0] H_W = 16'(H);

    state_e       state_q, state_d;
    logic [15:0]  count_q, count_d;
    logic [15:0]  index_q, index_d;
    logic [1:0]   lane_q, lane_d;
    logic [23:0]  asm_q, asm_d;
    logic         byte_ready_q, byte_ready_d;
    logic         wr_en_q, wr_en_d;
    logic [N-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]  wr_data_q, wr_data_d;
    logic         cpu_hold_q, cpu_hold_d;
    logic         load_done_q, load_done_d;
    logic         load_error_q, load_error_d;
    logic         fire_s;
    logic [15:0]  hdr_count_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]   chk_q, chk_d;
`endif

    assign fire_s      = bus.byte_valid && byte_ready_q;
    assign hdr_count_s = {bus.byte_in, count_q[7:0]};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        lane_d    = lane_q;
        asm_d     = asm_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d     = chk_q;
        if (fire_s) begin
            chk_d = chk_q ^ bus.byte_in;
        end else begin
            chk_d = chk_q;
        end
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_d = S_HDR_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR_LO: begin
                if (fire_s) begin
                    count_d[7:0] = bus.byte_in;
                    state_d      = S_HDR_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR_HI: begin
                if (fire_s) begin
                    count_d = hdr_count_s;
                    index_d = 16'd0;
                    lane_d  = 2'd0;
                    if (hdr_count_s > H_W) begin
                        state_d = S_ERR;
                    end else if (hdr_count_s == 16'd0) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DATA: begin
                if (fire_s) begin
                    case (lane_q)
                        2'd0:    asm_d[7:0]   = bus.byte_in;
                        2'd1:    asm_d[15:8]  = bus.byte_in;
                        2'd2:    asm_d[23:16] = bus.byte_in;
                        default: asm_d        = asm_q;
                    endcase
                    if (lane_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = N'({index_q, 2'b00});
                        wr_data_d = {bus.byte_in, asm_q};
                        lane_d    = 2'd0;
                        index_d   = index_q + 16'd1;
                        if (index_q == count_q - 16'd1) begin
                            state_d = S_AFTER_DATA;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (fire_s) begin
                    if (bus.byte_in == chk_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = 1'b0;
        load_done_d  = 1'b0;
        load_error_d = 1'b0;
        cpu_hold_d   = 1'b1;
        case (state_d)
            S_HDR_LO, S_HDR_HI, S_DATA: byte_ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                      byte_ready_d = 1'b1;
`endif
            S_DONE: begin
                load_done_d = 1'b1;
                cpu_hold_d  = 1'b0;
            end
            S_ERR:   load_error_d = 1'b1;
            default: byte_ready_d = 1'b0;
        endcase
    end

    // State and output registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= 16'd0;
            index_q      <= 16'd0;
            lane_q       <= 2'd0;
            asm_q        <= 24'd0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 32'd0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign cpu_hold       = cpu_hold_q;
    assign load_done      = load_done_q;
    assign load_error     = load_error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; works with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
    logic clk;
    logic reset;
    logic load_start;
    logic cpu_hold;
    logic load_done;
    logic load_error;

    imem_loader_if #(.N(32)) bus ();

    imem_loader #(.N(32), .H(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .bus        (bus.slave),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    logic [31:0] wa_log [$];
    logic [31:0] wd_log [$];
    logic        done_at_wr;
    logic        hold_at_wr;
    logic [7:0]  tb_xor;

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_cnt++;
            wa_log.push_back(bus.wr_addr);
            wd_log.push_back(bus.wr_data);
            done_at_wr = load_done;
            hold_at_wr = cpu_hold;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_byte(input logic [7:0] b);
        bit took = 1'b0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 20 && !took; i++) begin
            took = (bus.byte_ready === 1'b1);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        tb_xor = tb_xor ^ b;
        check_eq("handshake", {31'd0, took}, 32'd1);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        tb_xor = 8'h00;
    endtask

    task automatic send_good_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_xor);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int base;

    initial begin
        reset = 1'b1;
        load_start = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        tb_xor = 8'h00;
        idle(3);
        reset = 1'b0;
        #1;
        check_eq("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check_eq("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
        check_eq("rst_done", {31'd0, load_done}, 32'd0);
        check_eq("rst_err", {31'd0, load_error}, 32'd0);
        check_eq("rst_addr", bus.wr_addr, 32'd0);
        check_eq("rst_data", bus.wr_data, 32'd0);

        // Idle with a stray valid byte present.
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'hA5;
        idle(10);
        bus.byte_valid = 1'b0;
        #1;
        check_eq("idle_wr", wr_cnt, 0);
        check_eq("idle_ready", {31'd0, bus.byte_ready}, 32'd0);
        check_eq("idle_hold", {31'd0, cpu_hold}, 32'd1);

        // Two-word image.
        @(negedge clk);
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h30); send_byte(8'h00);
        #1;
`ifndef IMEM_LOADER_CHECKSUM_EN
        check_eq("done_with_wr", {31'd0, done_at_wr}, 32'd1);
        check_eq("hold_with_wr", {31'd0, hold_at_wr}, 32'd0);
`endif
        send_good_chk();
        #1;
        check_eq("img2_wrcnt", wr_cnt, 2);
        check_eq("img2_a0", wa_log[0], 32'h0000_0000);
        check_eq("img2_d0", wd_log[0], 32'h0010_0013);
        check_eq("img2_a1", wa_log[1], 32'h0000_0004);
        check_eq("img2_d1", wd_log[1], 32'h0030_0113);
        check_eq("img2_done", {31'd0, load_done}, 32'd1);
        check_eq("img2_hold", {31'd0, cpu_hold}, 32'd0);
        check_eq("img2_err", {31'd0, load_error}, 32'd0);
        check_eq("img2_ready", {31'd0, bus.byte_ready}, 32'd0);

        // Oversize header 17 > 16.
        @(negedge clk);
        pulse_start();
        send_byte(8'h11); send_byte(8'h00);
        #1;
        check_eq("big_err", {31'd0, load_error}, 32'd1);
        check_eq("big_ready", {31'd0, bus.byte_ready}, 32'd0);
        check_eq("big_done", {31'd0, load_done}, 32'd0);
        check_eq("big_hold", {31'd0, cpu_hold}, 32'd1);
        idle(3);
        check_eq("big_wrcnt", wr_cnt, 2);

        // Recovery with a one-word image.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_good_chk();
        #1;
        check_eq("rec_wrcnt", wr_cnt, 3);
        check_eq("rec_a", wa_log[2], 32'h0000_0000);
        check_eq("rec_d", wd_log[2], 32'h0000_006F);
        check_eq("rec_done", {31'd0, load_done}, 32'd1);
        check_eq("rec_err", {31'd0, load_error}, 32'd0);

        // Full-depth image (count == H), word i = 0x5A00_0000 | i.
        @(negedge clk);
        pulse_start();
        base = wr_cnt;
        send_byte(8'h10); send_byte(8'h00);
        for (int w = 0; w < 16; w++) begin
            send_byte(8'(w)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);
        end
        send_good_chk();
        #1;
        check_eq("full_wrcnt", wr_cnt, base + 16);
        check_eq("full_a15", wa_log[base + 15], 32'h0000_003C);
        check_eq("full_d15", wd_log[base + 15], 32'h5A00_000F);
        check_eq("full_a7", wa_log[base + 7], 32'h0000_001C);
        check_eq("full_done", {31'd0, load_done}, 32'd1);

        // Reset after 6 data bytes of a 3-word image.
        @(negedge clk);
        pulse_start();
        base = wr_cnt;
        check_eq("reload_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        #1;
        check_eq("mid_wrcnt", wr_cnt, base + 1);
        check_eq("mid_d", wd_log[base], 32'h4433_2211);
        check_eq("mid_hold", {31'd0, cpu_hold}, 32'd1);
        check_eq("mid_ready", {31'd0, bus.byte_ready}, 32'd0);
        check_eq("mid_done", {31'd0, load_done}, 32'd0);

        // Empty image.
        @(negedge clk);
        pulse_start();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h00);
        send_good_chk();
        #1;
        check_eq("zero_wrcnt", wr_cnt, base);
        check_eq("zero_done", {31'd0, load_done}, 32'd1);
        check_eq("zero_hold", {31'd0, cpu_hold}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Explicit checksum good / bad.
        @(negedge clk);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h6E);
        #1;
        check_eq("chk_ok_done", {31'd0, load_done}, 32'd1);
        check_eq("chk_ok_err", {31'd0, load_error}, 32'd0);
        @(negedge clk);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h6F);
        #1;
        check_eq("chk_bad_err", {31'd0, load_error}, 32'd1);
        check_eq("chk_bad_done", {31'd0, load_done}, 32'd0);
        check_eq("chk_bad_hold", {31'd0, cpu_hold}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
